// File: rtl/reg_write_decoder_pkg.sv
// Shared sizing helpers and defaults for the register-file write-enable decoder.
package reg_write_decoder_pkg;
    localparam int CONFLICT_CNT_W    = 16;
    localparam int DEFAULT_ADDR_W    = 5;
    localparam int DEFAULT_NUM_PORTS = 2;
    localparam int DEFAULT_ZERO_REG  = 31;

    function automatic int num_regs(input int addr_w);
        return 1 << addr_w;
    endfunction

    typedef logic [DEFAULT_NUM_PORTS-1:0][DEFAULT_ADDR_W-1:0] port_addr_t;
endpackage

// File: rtl/reg_write_decoder_pipe_onehot_decoder.sv
// Combinational enable + address to one-hot decoder of width 2**ADDR_W.
module onehot_decoder #(
    parameter int ADDR_W = 5
) (
    input  logic                     en,
    input  logic [ADDR_W-1:0]        addr,
    output logic [(1<<ADDR_W)-1:0]   onehot
);
    // Address is only looked at when enabled, so an unknown address on an idle port stays contained.
    always_comb begin
        onehot = '0;
        if (en) onehot[addr] = 1'b1;
    end
endmodule

// File: rtl/reg_write_decoder_pipe.sv
// Registered multi-port register-file write-enable decoder with fixed port priority,
// zero-register suppression, sticky dirty bits and a saturating conflict counter.
module reg_write_decoder_pipe
    import reg_write_decoder_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int NUM_PORTS   = DEFAULT_NUM_PORTS,
    parameter int ZERO_REG_EN = 1,
    parameter int ZERO_REG    = DEFAULT_ZERO_REG,
    localparam int NUM_REGS   = num_regs(ADDR_W)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               flush,
    input  logic [NUM_PORTS-1:0]               regWrite,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]   writeRegister,
    input  logic                               clearDirty,
    output logic [NUM_REGS-1:0]                out,
    output logic [NUM_PORTS-1:0]               grant,
    output logic                               conflict,
    output logic [CONFLICT_CNT_W-1:0]          conflictCount,
    output logic [NUM_REGS-1:0]                dirty
);
    logic [NUM_PORTS-1:0]               elig;
    logic [NUM_PORTS-1:0]               granted;
    logic [NUM_PORTS-1:0][NUM_REGS-1:0] dec;
    logic [NUM_REGS-1:0]                out_nxt;
    logic                               conflict_nxt;

    always_comb begin
        elig    = '0;
        granted = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            elig[p] = regWrite[p] &&
                      !((ZERO_REG_EN != 0) && (32'(writeRegister[p]) == ZERO_REG));
        end
        // A lower-numbered eligible port to the same register shadows this one.
        for (int p = 0; p < NUM_PORTS; p++) begin
            granted[p] = elig[p];
            for (int q = 0; q < p; q++) begin
                if (elig[q] && (writeRegister[q] == writeRegister[p])) granted[p] = 1'b0;
            end
        end
        conflict_nxt = |(elig & ~granted);
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
        onehot_decoder #(.ADDR_W(ADDR_W)) u_dec (
            .en     (granted[p]),
            .addr   (writeRegister[p]),
            .onehot (dec[p])
        );
    end

    always_comb begin
        out_nxt = '0;
        for (int p = 0; p < NUM_PORTS; p++) out_nxt = out_nxt | dec[p];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out           <= '0;
            grant         <= '0;
            conflict      <= 1'b0;
            conflictCount <= '0;
            dirty         <= '0;
        end else if (flush) begin
            out      <= '0;
            grant    <= '0;
            conflict <= 1'b0;
        end else begin
            out      <= out_nxt;
            grant    <= granted;
            conflict <= conflict_nxt;
            if (conflict_nxt && (conflictCount != '1)) conflictCount <= conflictCount + 1'b1;
            // Set beats clear so a write in the clearing cycle is not lost.
            dirty <= (clearDirty ? '0 : dirty) | out_nxt;
        end
    end
endmodule

// File: tb/tb_reg_write_decoder_pipe.sv
// Directed self-checking bench for reg_write_decoder_pipe (default, no-zero-reg and 3-port/4-bit builds).
module tb_reg_write_decoder_pipe;
    logic             clk = 1'b0;
    logic             reset_n;
    logic             flush, clr;
    logic [1:0]       rw;
    logic [1:0][4:0]  wr;
    logic [31:0]      out0, dirty0, out_nz, dirty_nz;
    logic [1:0]       grant0, grant_nz;
    logic             conf0, conf_nz;
    logic [15:0]      cnt0, cnt_nz;

    logic             flush3, clr3;
    logic [2:0]       rw3;
    logic [2:0][3:0]  wr3;
    logic [15:0]      out3, dirty3;
    logic [2:0]       grant3;
    logic             conf3;
    logic [15:0]      cnt3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_write_decoder_pipe dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .regWrite(rw), .writeRegister(wr),
        .clearDirty(clr), .out(out0), .grant(grant0), .conflict(conf0),
        .conflictCount(cnt0), .dirty(dirty0)
    );

    reg_write_decoder_pipe #(.ZERO_REG_EN(0)) dut_nz (
        .clk(clk), .reset_n(reset_n), .flush(flush), .regWrite(rw), .writeRegister(wr),
        .clearDirty(clr), .out(out_nz), .grant(grant_nz), .conflict(conf_nz),
        .conflictCount(cnt_nz), .dirty(dirty_nz)
    );

    reg_write_decoder_pipe #(.ADDR_W(4), .NUM_PORTS(3), .ZERO_REG(15)) dut3 (
        .clk(clk), .reset_n(reset_n), .flush(flush3), .regWrite(rw3), .writeRegister(wr3),
        .clearDirty(clr3), .out(out3), .grant(grant3), .conflict(conf3),
        .conflictCount(cnt3), .dirty(dirty3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rw = 2'b00; wr = '0; flush = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rw = 2'b11; wr[0] = 5'd5; wr[1] = 5'd6; flush = 1'b0; clr = 1'b0;
        rw3 = 3'b111; wr3 = '0; flush3 = 1'b0; clr3 = 1'b0;
        tick(); tick();
        checks++; if (out0 !== 32'h0) begin failures++; $display("FAIL reset_out got=%h exp=%h", out0, 32'h0); end
        checks++; if (grant0 !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant0); end
        checks++; if (conf0 !== 1'b0) begin failures++; $display("FAIL reset_conflict got=%b exp=0", conf0); end
        checks++; if (cnt0 !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0000", cnt0); end
        checks++; if (dirty0 !== 32'h0) begin failures++; $display("FAIL reset_dirty got=%h exp=0", dirty0); end
        checks++; if (out3 !== 16'h0) begin failures++; $display("FAIL reset_out3 got=%h exp=0", out3); end
        reset_n = 1'b1;
        rw3 = 3'b000;
        rw = 2'b01; wr[0] = 5'd5; wr[1] = 5'd0;
        tick();
        checks++; if (out0 !== 32'h0000_0020) begin failures++; $display("FAIL first_out got=%h exp=%h", out0, 32'h20); end
        checks++; if (grant0 !== 2'b01) begin failures++; $display("FAIL first_grant got=%b exp=01", grant0); end
        checks++; if (dirty0 !== 32'h0000_0020) begin failures++; $display("FAIL first_dirty got=%h exp=%h", dirty0, 32'h20); end
        idle();
        tick();
        checks++; if (out0 !== 32'h0 || grant0 !== 2'b00) begin failures++; $display("FAIL idle_out got=%h/%b exp=0/00", out0, grant0); end
    endtask

    task automatic test_conflict();
        rw = 2'b11; wr[0] = 5'd3; wr[1] = 5'd3;
        tick();
        checks++; if (out0 !== 32'h0000_0008) begin failures++; $display("FAIL conf_out got=%h exp=%h", out0, 32'h8); end
        checks++; if (grant0 !== 2'b01) begin failures++; $display("FAIL conf_grant got=%b exp=01", grant0); end
        checks++; if (conf0 !== 1'b1) begin failures++; $display("FAIL conf_flag got=%b exp=1", conf0); end
        checks++; if (cnt0 !== 16'd1) begin failures++; $display("FAIL conf_count got=%0d exp=1", cnt0); end
        rw = 2'b10; wr[0] = 5'd0; wr[1] = 5'd3;
        tick();
        checks++; if (grant0 !== 2'b10) begin failures++; $display("FAIL p1_grant got=%b exp=10", grant0); end
        checks++; if (conf0 !== 1'b0) begin failures++; $display("FAIL p1_conflict got=%b exp=0", conf0); end
        checks++; if (cnt0 !== 16'd1) begin failures++; $display("FAIL p1_count got=%0d exp=1", cnt0); end
        idle();
    endtask

    task automatic test_zero_reg();
        rw = 2'b11; wr[0] = 5'd31; wr[1] = 5'd7;
        tick();
        checks++; if (out0 !== 32'h0000_0080) begin failures++; $display("FAIL zr_out got=%h exp=%h", out0, 32'h80); end
        checks++; if (grant0 !== 2'b10) begin failures++; $display("FAIL zr_grant got=%b exp=10", grant0); end
        checks++; if (conf0 !== 1'b0) begin failures++; $display("FAIL zr_conflict got=%b exp=0", conf0); end
        checks++; if (dirty0[31] !== 1'b0) begin failures++; $display("FAIL zr_dirty31 got=%b exp=0", dirty0[31]); end
        checks++; if (out_nz !== 32'h8000_0080) begin failures++; $display("FAIL nz_out got=%h exp=%h", out_nz, 32'h80000080); end
        checks++; if (grant_nz !== 2'b11) begin failures++; $display("FAIL nz_grant got=%b exp=11", grant_nz); end
        idle();
    endtask

    task automatic test_flush();
        flush = 1'b1; rw = 2'b01; wr[0] = 5'd9;
        tick();
        checks++; if (out0 !== 32'h0) begin failures++; $display("FAIL flush_out got=%h exp=0", out0); end
        checks++; if (grant0 !== 2'b00) begin failures++; $display("FAIL flush_grant got=%b exp=00", grant0); end
        checks++; if (dirty0 !== 32'h0000_00A8) begin failures++; $display("FAIL flush_dirty got=%h exp=%h", dirty0, 32'hA8); end
        checks++; if (cnt0 !== 16'd1) begin failures++; $display("FAIL flush_count got=%0d exp=1", cnt0); end
        flush = 1'b1; rw = 2'b11; wr[0] = 5'd2; wr[1] = 5'd2;
        tick();
        checks++; if (conf0 !== 1'b0 || cnt0 !== 16'd1) begin failures++; $display("FAIL flush_conf got=%b/%0d exp=0/1", conf0, cnt0); end
        idle();
    endtask

    task automatic test_clear_dirty();
        rw = 2'b01; wr[0] = 5'd4;
        tick();
        rw = 2'b10; wr[0] = 5'd0; wr[1] = 5'd12;
        tick();
        checks++; if (dirty0 !== 32'h0000_10B8) begin failures++; $display("FAIL pre_clear_dirty got=%h exp=%h", dirty0, 32'h10B8); end
        clr = 1'b1; rw = 2'b10; wr[1] = 5'd12;
        tick();
        checks++; if (dirty0 !== 32'h0000_1000) begin failures++; $display("FAIL clear_dirty got=%h exp=%h", dirty0, 32'h1000); end
        clr = 1'b1; rw = 2'b00;
        tick();
        checks++; if (dirty0 !== 32'h0) begin failures++; $display("FAIL clear_only got=%h exp=0", dirty0); end
        idle();
    endtask

    task automatic test_saturate();
        rw = 2'b11; wr[0] = 5'd2; wr[1] = 5'd2;
        repeat (65540) @(posedge clk);
        #1;
        checks++; if (cnt0 !== 16'hFFFF) begin failures++; $display("FAIL sat_count got=%h exp=FFFF", cnt0); end
        tick();
        checks++; if (cnt0 !== 16'hFFFF || conf0 !== 1'b1) begin failures++; $display("FAIL sat_hold got=%h/%b exp=FFFF/1", cnt0, conf0); end
        idle();
        tick();
    endtask

    task automatic test_sweep();
        logic [31:0] e32;
        logic [15:0] e16;
        logic [1:0]  g2;
        logic [2:0]  g3;
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < 32; r++) begin
                rw = 2'b00; rw[p] = 1'b1;
                wr = 'x; wr[p] = 5'(r);
                e32 = (r == 31) ? 32'h0 : (32'h1 << r);
                g2 = 2'b00; if (r != 31) g2[p] = 1'b1;
                tick();
                checks++; if (out0 !== e32 || grant0 !== g2) begin failures++; $display("FAIL sweep p%0d r%0d got=%h/%b exp=%h/%b", p, r, out0, grant0, e32, g2); end
            end
        end
        idle();
        for (int p = 0; p < 3; p++) begin
            for (int r = 0; r < 16; r++) begin
                rw3 = 3'b000; rw3[p] = 1'b1;
                wr3 = 'x; wr3[p] = 4'(r);
                e16 = (r == 15) ? 16'h0 : (16'h1 << r);
                g3 = 3'b000; if (r != 15) g3[p] = 1'b1;
                tick();
                checks++; if (out3 !== e16 || grant3 !== g3) begin failures++; $display("FAIL sweep3 p%0d r%0d got=%h/%b exp=%h/%b", p, r, out3, grant3, e16, g3); end
            end
        end
        rw3 = 3'b111; wr3[0] = 4'd6; wr3[1] = 4'd6; wr3[2] = 4'd6;
        tick();
        checks++; if (out3 !== 16'h0040 || grant3 !== 3'b001 || conf3 !== 1'b1) begin failures++; $display("FAIL p3_all_same got=%h/%b/%b exp=0040/001/1", out3, grant3, conf3); end
        rw3 = 3'b111; wr3[0] = 4'd2; wr3[1] = 4'd8; wr3[2] = 4'd8;
        tick();
        checks++; if (out3 !== 16'h0104 || grant3 !== 3'b011 || cnt3 !== 16'd2) begin failures++; $display("FAIL p3_pair got=%h/%b/%0d exp=0104/011/2", out3, grant3, cnt3); end
        rw3 = 3'b110; wr3[0] = 4'd2; wr3[1] = 4'd15; wr3[2] = 4'd15;
        tick();
        checks++; if (out3 !== 16'h0 || grant3 !== 3'b000 || conf3 !== 1'b0) begin failures++; $display("FAIL p3_zero got=%h/%b/%b exp=0000/000/0", out3, grant3, conf3); end
        rw3 = 3'b000;
    endtask

    task automatic test_reset_midstream();
        rw = 2'b11; wr[0] = 5'd1; wr[1] = 5'd1;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (cnt0 !== 16'h0 || dirty0 !== 32'h0 || out0 !== 32'h0 || grant0 !== 2'b00) begin
            failures++; $display("FAIL midreset got=%h/%h/%h/%b exp=0/0/0/00", cnt0, dirty0, out0, grant0); end
        tick();
        reset_n = 1'b1;
        rw = 2'b01; wr[0] = 5'd5; wr[1] = 5'd0;
        tick();
        checks++; if (out0 !== 32'h20 || grant0 !== 2'b01 || dirty0 !== 32'h20 || cnt0 !== 16'h0) begin
            failures++; $display("FAIL post_reset got=%h/%b/%h/%h exp=20/01/20/0", out0, grant0, dirty0, cnt0); end
        idle();
    endtask

    initial begin
        test_reset();
        test_conflict();
        test_zero_reg();
        test_flush();
        test_clear_dirty();
        test_saturate();
        test_sweep();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
